// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU/register-file command sequencer.
// Optional build macro: ALU_SEQ_OF_TRAP_EN (suppresses write-back on add/sub overflow).
package alu_seq_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        WB   = 2'd2,
        RESP = 2'd3
    } seq_state_e;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_OR  = 3'd1;
    localparam logic [2:0] OP_XOR = 3'd2;
    localparam logic [2:0] OP_NOR = 3'd3;
    localparam logic [2:0] OP_ADD = 3'd4;
    localparam logic [2:0] OP_SUB = 3'd5;
    localparam logic [2:0] OP_SLT = 3'd6;
    localparam logic [2:0] OP_SLL = 3'd7;

    // Opcodes whose OF flag is meaningful (signed add/sub)
    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_reg_sequencer.sv
// Command-driven initiator for the register-file/ALU datapath: one operation
// per command handshake, result and flags returned on a valid/ready response.
// Optional build macro: ALU_SEQ_OF_TRAP_EN -- an add/sub with OF=1 skips the
// register write (rsp_wrote=0) while keeping the same four-cycle sequence.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | cmd_ready=1, waiting for a command
// READ  | addresses/opcode driven, F/ZF/OF captured at end of cycle
// WB    | datapath outputs held, Write_Reg pulsed if write-back enabled
// RESP  | rsp_valid=1 until rsp_ready, then count and return to IDLE
module alu_reg_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    input  logic              cmd_wb,
    output logic [ADDR_W-1:0] R_Addr_A,
    output logic [ADDR_W-1:0] R_Addr_B,
    output logic [ADDR_W-1:0] W_Addr,
    output logic [2:0]        ALU_OP,
    output logic              Write_Reg,
    input  logic [DATA_W-1:0] F,
    input  logic              ZF,
    input  logic              OF,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_zf,
    output logic              rsp_of,
    output logic              rsp_wrote,
    output logic [CNT_W-1:0]  ops_done
);

    seq_state_e state;
    logic       wb_q;
    logic       wr_en;

    // Write-back decision made at the end of READ from the latched command
    // and the flag being captured on that same edge.
    always_comb begin
        wr_en = wb_q;
`ifdef ALU_SEQ_OF_TRAP_EN
        if (is_arith(ALU_OP) && OF) begin
            wr_en = 1'b0;
        end
`endif
    end

    // Sequencer FSM with all outputs registered; reset forces IDLE and
    // drops Write_Reg immediately.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            cmd_ready <= 1'b1;
            wb_q      <= 1'b0;
            R_Addr_A  <= '0;
            R_Addr_B  <= '0;
            W_Addr    <= '0;
            ALU_OP    <= '0;
            Write_Reg <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_zf    <= 1'b0;
            rsp_of    <= 1'b0;
            rsp_wrote <= 1'b0;
            ops_done  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        R_Addr_A  <= cmd_rs;
                        R_Addr_B  <= cmd_rt;
                        W_Addr    <= cmd_rd;
                        ALU_OP    <= cmd_op;
                        wb_q      <= cmd_wb;
                        cmd_ready <= 1'b0;
                        state     <= READ;
                    end
                end
                READ: begin
                    rsp_data  <= F;
                    rsp_zf    <= ZF;
                    rsp_of    <= OF;
                    rsp_wrote <= wr_en;
                    Write_Reg <= wr_en;
                    state     <= WB;
                end
                WB: begin
                    Write_Reg <= 1'b0;
                    R_Addr_A  <= '0;
                    R_Addr_B  <= '0;
                    W_Addr    <= '0;
                    ALU_OP    <= '0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_done  <= ops_done + CNT_W'(1);
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    Write_Reg <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/alu_reg_sequencer.md
# alu_reg_sequencer

Command-driven controller that is the initiator on the register-file/ALU datapath interface: it accepts one operation per command handshake, drives the read addresses, ALU opcode, write address and write strobe, and returns the captured result. The block sits between a command source (test host, future instruction decoder) and the datapath. The datapath's register write data is its ALU result F.

## Interface
- DATA_W, 32, datapath and result width
- ADDR_W, 5, register address width (32 registers)
- CNT_W, 16, width of the completed-operation counter

- clk  in  1  single clock, all state on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  ALU opcode: 0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt, 7 sll
- cmd_rs, cmd_rt, cmd_rd  in  ADDR_W each  source A, source B, destination
- cmd_wb  in  1  write result back to cmd_rd
- R_Addr_A, R_Addr_B, W_Addr  out  ADDR_W each  datapath addresses
- ALU_OP  out  3  datapath opcode
- Write_Reg  out  1  register write strobe
- F  in  DATA_W  ALU result (also the datapath's write data)
- ZF, OF  in  1 each  ALU zero and overflow flags
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer takes result
- rsp_data  out  DATA_W  captured F
- rsp_zf, rsp_of  out  1 each  captured flags
- rsp_wrote  out  1  Write_Reg was actually asserted for this command
- ops_done  out  CNT_W  completed-response count

## Operation
- States: IDLE, READ, WB, RESP; the state register resets asynchronously to IDLE.
- IDLE
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch op/rs/rt/rd/wb and go to READ.
- READ
  - Drive R_Addr_A=rs, R_Addr_B=rt, ALU_OP=op, W_Addr=rd.
  - At the end of the cycle, capture F, ZF and OF into the result registers, then go to WB.
- WB
  - Hold all datapath outputs unchanged.
  - Write_Reg=1 for exactly this cycle if the latched wb=1 (subject to Configuration); then go to RESP.
- RESP
  - rsp_valid=1; rsp_* are held stable.
  - Datapath outputs return to 0.
  - On rsp_ready, increment ops_done and go to IDLE.
- Outside READ/WB, the address/opcode outputs are 0 and Write_Reg=0. Write_Reg is decoded from the state register only, never from cmd_* inputs.
- cmd_ready=0 in every state except IDLE. A new command is never accepted in the same cycle as the RESP handshake.
- ops_done wraps from 2^CNT_W-1 to 0; it is cleared only by reset.
- rd=0 is a normal writable register; no special casing.

## Timing
- Reset values:
  - cmd_ready=1 (IDLE).
  - rsp_valid=0, Write_Reg=0, every address/opcode output 0.
  - rsp_data=0, rsp_zf=0, rsp_of=0, rsp_wrote=0, ops_done=0.
- Latency: accept edge at cycle 0; READ in cycle 1; WB (Write_Reg) in cycle 2; rsp_valid from cycle 3.
- Minimum command-to-command spacing is 4 cycles when rsp_ready is held high.
- rsp_valid, once high, stays high with stable data until rsp_ready is sampled high.
- Reset_n low in any state:
  - Immediate return to IDLE.
  - Write_Reg drops asynchronously; no partial write on the next edge.
  - The in-flight command is lost and ops_done is cleared.
- The datapath F is combinational from the register array. READ gives one full cycle for it to settle before capture.

## Configuration
- ALU_SEQ_OF_TRAP_EN defined:
  - For op 4 or 5, a captured OF=1 suppresses Write_Reg in WB.
  - rsp_of=1 and rsp_wrote=0; the WB state is still traversed, so latency is unchanged.
- Undefined: Write_Reg follows cmd_wb alone, and rsp_wrote equals the latched wb.

## Structure
- Shared package alu_seq_pkg holds:
  - the state enum (IDLE, READ, WB, RESP);
  - ALU opcode constants OP_AND..OP_SLL (0..7);
  - the DATA_W/ADDR_W defaults.
- No sub-module: the FSM, latches and counter fit naturally in one module.

## Test plan
The bench models the datapath: 32x32 register array, F=op(A,B), ZF=(F==0), with add/sub OF as signed overflow.
- Reset, then cmd nor r0,r0→r1, wb=1 → Write_Reg high exactly one cycle (cycle 2, W_Addr=1); rsp_data=0xFFFFFFFF, zf=0; r1=0xFFFFFFFF; ops_done=1.
- sub r1,r1→r2, wb=1 → rsp_data=0, rsp_zf=1; r2=0.
- Registers preloaded r3=0x7FFFFFFF, r4=1; add r3,r4→r5 → rsp_of=1.
  - With ALU_SEQ_OF_TRAP_EN: r5 unchanged, rsp_wrote=0.
  - Without it: r5=0x80000000, rsp_wrote=1.
- Hold rsp_ready=0 for 10 cycles while cmd_valid=1 → rsp_valid and rsp_data stable, cmd_ready=0; the second command is accepted only after the handshake.
- Assert Reset_n low during WB → Write_Reg falls before the next edge, destination unchanged, state IDLE, ops_done=0.
- Force ops_done to 0xFFFF via 65535 back-to-back commands with wb=0 → the next response wraps the counter to 0; no register is modified.
